// File: rtl/mac_lane_ctrl.sv
// Sequencer for one MAC lane: clears the lane, streams N operand chunks, waits out
// the lane latency, then holds the result until it is accepted. Optional perf counters: MAC_LANE_CTRL_PERF_EN.
module mac_lane_ctrl #(
    parameter int IL       = 4,
    parameter int FL       = 16,
    parameter int CNT_W    = 8,
    parameter int LANE_LAT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_chunks,
    input  logic                act_mode,
    output logic                busy,
    output logic                rd_en,
    output logic [CNT_W-1:0]    rd_addr,
    output logic                op_gate,
    output logic                lane_reset,
    output logic                lane_mode,
    input  logic [IL+FL-1:0]    lane_f,
    output logic [IL+FL-1:0]    result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                done,
    output logic [31:0]         perf_cycles,
    output logic [15:0]         perf_jobs,
    output logic [2:0]          state_dbg
);

    localparam int DW = $clog2(LANE_LAT + 1) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LANE_LAT);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [DW-1:0]    drain_cnt;

    assign state_dbg = state;

    // Result handshake: result_valid rises with the captured result and both stay
    // stable until an edge sees result_ready=1; that edge completes the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            op_gate      <= 1'b0;
            lane_reset   <= 1'b1;
            lane_mode    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
            n_lat        <= '0;
            drain_cnt    <= '0;
        end else begin
            op_gate    <= rd_en;
            done       <= 1'b0;
            lane_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && num_chunks != '0) begin
                        n_lat      <= num_chunks;
                        lane_mode  <= act_mode;
                        lane_reset <= 1'b1;
                        busy       <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                    state   <= FEED;
                end
                FEED: begin
                    // Compare against N-1 so N = 2^CNT_W-1 never wraps the address.
                    if (rd_addr == n_lat - CNT_W'(1)) begin
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        result       <= lane_f;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_LANE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (done && perf_jobs != '1)   perf_jobs   <= perf_jobs + 16'd1;
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_jobs   = '0;
`endif

endmodule
